// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and word geometry.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words; word_full_o flags the
// cycle on which the 4th byte of a word is being loaded.
module word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (en_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      // 2-bit index wraps back to byte 0 after the 4th byte
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = en_i && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/boot_loader.sv
// Streams bytes into instruction memory as 32-bit words while holding the core
// in reset, then releases the core once the requested word count is written.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] widx_q, widx_d;
  logic             asm_clr;
  logic             accept;
  logic             word_full;
  logic [31:0]      word;

  assign accept = byte_valid && byte_ready;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (asm_clr),
    .en_i       (accept),
    .byte_i     (byte_data),
    .word_o     (word),
    .word_full_o(word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    asm_clr = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          cnt_d   = word_count;
          widx_d  = '0;
          asm_clr = 1'b1;
          state_d = (word_count == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        if (widx_q == cnt_q - CNT_W'(1)) begin
          state_d = RUN;
        end else begin
          widx_d  = widx_q + CNT_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a decode of the state register; byte_ready never sees byte_valid.
  assign byte_ready = (state_q == LOAD);
  assign imem_we    = (state_q == WRITE);
  assign busy       = (state_q == LOAD) || (state_q == WRITE);
  assign done       = (state_q == RUN);
  assign core_rst   = (state_q != RUN);
  assign imem_addr  = imem_we ? (BASE_ADDR + {30'(widx_q), 2'b00}) : 32'h0;
  assign imem_wdata = imem_we ? word : 32'h0;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued as bytes are
// driven and popped by a per-instance monitor on each imem_we.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] wc = '0;
  logic        bv = 1'b0;
  logic [7:0]  bd = '0;

  logic        a_rdy, a_we, a_core, a_busy, a_done;
  logic [31:0] a_addr, a_wdata;
  logic        b_rdy, b_we, b_core, b_busy, b_done;
  logic [31:0] b_addr, b_wdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea, eb;

  always #5 clk = ~clk;

  boot_loader #(.BASE_ADDR(32'h0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .word_count(wc),
    .byte_valid(bv), .byte_data(bd), .byte_ready(a_rdy),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .core_rst(a_core), .busy(a_busy), .done(a_done)
  );

  boot_loader #(.BASE_ADDR(32'h100), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .word_count(wc),
    .byte_valid(bv), .byte_data(bd), .byte_ready(b_rdy),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .core_rst(b_core), .busy(b_busy), .done(b_done)
  );

  always @(negedge clk) begin
    total++;
    if (a_we) begin
      if (qa.size() == 0) begin
        bad++; $display("FAIL a_unexpected_write got addr=%h data=%h want none", a_addr, a_wdata);
      end else begin
        ea = qa.pop_front();
        if ({a_addr, a_wdata} !== ea) begin
          bad++; $display("FAIL a_write got %h want %h", {a_addr, a_wdata}, ea);
        end
      end
    end else if ({a_addr, a_wdata} !== 64'h0) begin
      bad++; $display("FAIL a_idle_bus got %h want 0", {a_addr, a_wdata});
    end
    total++;
    if (b_we) begin
      if (qb.size() == 0) begin
        bad++; $display("FAIL b_unexpected_write got addr=%h data=%h want none", b_addr, b_wdata);
      end else begin
        eb = qb.pop_front();
        if ({b_addr, b_wdata} !== eb) begin
          bad++; $display("FAIL b_write got %h want %h", {b_addr, b_wdata}, eb);
        end
      end
    end else if ({b_addr, b_wdata} !== 64'h0) begin
      bad++; $display("FAIL b_idle_bus got %h want 0", {b_addr, b_wdata});
    end
  end

  // Holds byte d valid until the selected instance accepts it; returns at edge+1.
  task automatic send_byte(input bit sel, input logic [7:0] d);
    int n = 0;
    bv = 1'b1;
    bd = d;
    while (!(sel ? b_rdy : a_rdy) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL byte_timeout got ready=0 want ready=1 within 20 cycles");
    end
    @(posedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(sel, w[i*8 +: 8]);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({a_core, a_rdy, a_we, a_busy, a_done} !== 5'b10000) begin
      bad++; $display("FAIL reset_a_flags got %b want 10000", {a_core, a_rdy, a_we, a_busy, a_done});
    end
    total++;
    if ({b_core, b_rdy, b_we, b_busy, b_done} !== 5'b10000) begin
      bad++; $display("FAIL reset_b_flags got %b want 10000", {b_core, b_rdy, b_we, b_busy, b_done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a_core, a_busy, a_done} !== 3'b100) begin
      bad++; $display("FAIL reset_idle got %b want 100", {a_core, a_busy, a_done});
    end
  endtask

  task automatic test_two_words();
    qa.push_back({32'h0, 32'h0050_0013});
    qa.push_back({32'h4, 32'h00A0_0093});
    wc = 16'd2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if ({a_core, a_rdy, a_busy, a_done} !== 4'b1110) begin
      bad++; $display("FAIL two_load_flags got %b want 1110", {a_core, a_rdy, a_busy, a_done});
    end
    send_word(1'b0, 32'h0050_0013);
    send_word(1'b0, 32'h00A0_0093);
    total++;
    if ({a_we, a_core} !== 2'b11) begin
      bad++; $display("FAIL two_we_latency got we,core=%b want 11", {a_we, a_core});
    end
    @(posedge clk); #1;
    total++;
    if ({a_core, a_done, a_busy, a_rdy} !== 4'b0100) begin
      bad++; $display("FAIL two_run got %b want 0100", {a_core, a_done, a_busy, a_rdy});
    end
    total++;
    if (qa.size() !== 0) begin
      bad++; $display("FAIL two_pending got %0d want 0", qa.size());
    end
  endtask

  task automatic test_zero_count();
    pulse_rst();
    wc = 16'd0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if ({a_done, a_core, a_busy} !== 3'b100) begin
      bad++; $display("FAIL zero_run got %b want 100", {a_done, a_core, a_busy});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (a_done !== 1'b1) begin
      bad++; $display("FAIL zero_stay got done=%b want 1", a_done);
    end
  endtask

  task automatic test_toggle();
    logic [6:0] pat;
    logic [7:0] bytes [4];
    int k = 0;
    pat = 7'b1101001;
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    qa.push_back({32'h0, 32'hEFBE_ADDE});
    wc = 16'd1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++;
    if (a_core !== 1'b1) begin
      bad++; $display("FAIL toggle_core_rst got %b want 1", a_core);
    end
    for (int i = 0; i < 7; i++) begin
      bv = pat[i];
      bd = bytes[k];
      total++;
      if (a_rdy !== 1'b1) begin
        bad++; $display("FAIL toggle_ready cycle %0d got %b want 1", i, a_rdy);
      end
      @(posedge clk); #1;
      if (pat[i]) k++;
    end
    bv = 1'b0;
    total++;
    if (a_we !== 1'b1) begin
      bad++; $display("FAIL toggle_we got %b want 1", a_we);
    end
    @(posedge clk); #1;
    total++;
    if ({a_done, a_core} !== 2'b10 || qa.size() !== 0) begin
      bad++; $display("FAIL toggle_end got done,core=%b pending=%0d want 10 and 0", {a_done, a_core}, qa.size());
    end
  endtask

  task automatic test_reset_midload();
    qa.push_back({32'h0, 32'h0302_0100});
    wc = 16'd2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    send_word(1'b0, 32'h0302_0100);
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h05);
    rst = 1'b1;
    #1;
    total++;
    if ({a_core, a_busy, a_we, a_rdy, a_done} !== 5'b10000) begin
      bad++; $display("FAIL midrst_flags got %b want 10000", {a_core, a_busy, a_we, a_rdy, a_done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bv = 1'b1;
    bd = 8'h06;
    repeat (3) @(posedge clk);
    #1;
    bv = 1'b0;
    total++;
    if ({a_core, a_busy, a_done} !== 3'b100 || qa.size() !== 0) begin
      bad++; $display("FAIL midrst_idle got %b pending=%0d want 100 and 0", {a_core, a_busy, a_done}, qa.size());
    end
    qa.push_back({32'h0, 32'hCAFE_F00D});
    wc = 16'd1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    send_word(1'b0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    total++;
    if ({a_done, a_core} !== 2'b10 || qa.size() !== 0) begin
      bad++; $display("FAIL midrst_reload got done,core=%b pending=%0d want 10 and 0", {a_done, a_core}, qa.size());
    end
  endtask

  task automatic test_restart_run();
    wc = 16'd0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    total++;
    if ({b_done, b_core} !== 2'b10) begin
      bad++; $display("FAIL restart_prerun got %b want 10", {b_done, b_core});
    end
    qb.push_back({32'h100, 32'h7654_3210});
    wc = 16'd1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    total++;
    if ({b_core, b_busy, b_done} !== 3'b110) begin
      bad++; $display("FAIL restart_core_rst got %b want 110", {b_core, b_busy, b_done});
    end
    send_byte(1'b1, 8'h10);
    send_byte(1'b1, 8'h32);
    start_b = 1'b1;
    wc = 16'd5;
    send_byte(1'b1, 8'h54);
    start_b = 1'b0;
    send_byte(1'b1, 8'h76);
    total++;
    if (b_we !== 1'b1) begin
      bad++; $display("FAIL restart_we got %b want 1", b_we);
    end
    @(posedge clk); #1;
    total++;
    if ({b_done, b_core} !== 2'b10 || qb.size() !== 0) begin
      bad++; $display("FAIL restart_end got done,core=%b pending=%0d want 10 and 0", {b_done, b_core}, qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_toggle();
    test_reset_midload();
    test_restart_run();
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
